// File: rtl/pwm_demod_if.sv
// Bundle of the PWM demodulator's control input, PWM line and measurement report outputs.
// The master drives enable/pwm_in; the slave (the demodulator) drives the report fields.
interface pwm_demod_if #(
    parameter int RESOLUTION    = 8,
    parameter int COUNTER_WIDTH = 24
);
    logic                     enable;
    logic                     pwm_in;
    logic [RESOLUTION-1:0]    duty_out;
    logic [COUNTER_WIDTH-1:0] period_out;
    logic                     valid;
    logic                     timeout_flag;
    logic                     overrun;

    modport master (
        output enable, pwm_in,
        input  duty_out, period_out, valid, timeout_flag, overrun
    );

    modport slave (
        input  enable, pwm_in,
        output duty_out, period_out, valid, timeout_flag, overrun
    );
endinterface

// File: rtl/pwm_demod.sv
// PWM demodulator: measures each period of pwm_in and reports period plus duty scaled to RESOLUTION bits.
// Latency: report valid RESOLUTION+1 cycles after the synchronized rising edge that closes a period.
// No backpressure: a period closing while the divider is still busy is dropped with an overrun strobe.
module pwm_demod #(
    parameter int RESOLUTION    = 8,
    parameter int COUNTER_WIDTH = 24,
    parameter int TIMEOUT       = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    pwm_demod_if.slave bus
);
    localparam int CW  = COUNTER_WIDTH;
    localparam int DCW = $clog2(RESOLUTION + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [0:0] {IDLE, MEASURE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q;
    logic                  hist_q;
    logic [CW-1:0]         per_q, high_q, to_cnt_q;
    logic                  to_done_q, to_pend_q;
    logic                  busy_q;
    logic [DCW-1:0]        div_cnt_q;
    logic [CW-1:0]         rem_q, div_p_q;
    logic [RESOLUTION-2:0] quo_q;
    logic [RESOLUTION-1:0] duty_q;
    logic [CW-1:0]         period_q;
    logic                  valid_q, tflag_q, overrun_q;

    logic                  lvl, rise;
    logic                  restart, start_div, drop, fire;
    logic [CW:0]           rem_sh, dv;
    logic                  ge;
    logic [CW-1:0]         rem_sub;
    logic [RESOLUTION-1:0] quo_next;
    logic                  div_last;

    assign lvl  = sync_q[1];
    assign rise = sync_q[1] & ~hist_q;

    // One restoring-division step: the remainder always stays below the divisor.
    always_comb begin
        rem_sh   = {rem_q, 1'b0};
        dv       = {1'b0, div_p_q};
        ge       = (rem_sh >= dv);
        rem_sub  = ge ? CW'(rem_sh - dv) : rem_sh[CW-1:0];
        quo_next = {quo_q, ge};
        div_last = busy_q && (div_cnt_q == DCW'(1));
    end

    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        start_div = 1'b0;
        drop      = 1'b0;
        fire      = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = MEASURE;
                        restart = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        restart   = 1'b1;
                        start_div = ~busy_q;
                        drop      = busy_q;
                    end
                end
                default: state_d = IDLE;
            endcase
            // An edge in the very cycle the timeout would fire wins over the timeout.
            if (!rise && !to_done_q && (to_cnt_q == TO_VAL)) begin
                fire    = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            hist_q    <= 1'b0;
            per_q     <= '0;
            high_q    <= '0;
            to_cnt_q  <= '0;
            to_done_q <= 1'b0;
            to_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            div_cnt_q <= '0;
            rem_q     <= '0;
            div_p_q   <= '0;
            quo_q     <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            tflag_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], bus.pwm_in};
            hist_q    <= sync_q[1];
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            if (!bus.enable) begin
                state_q   <= IDLE;
                per_q     <= '0;
                high_q    <= '0;
                to_cnt_q  <= '0;
                to_done_q <= 1'b0;
                to_pend_q <= 1'b0;
                busy_q    <= 1'b0;
                div_cnt_q <= '0;
                rem_q     <= '0;
                div_p_q   <= '0;
                quo_q     <= '0;
            end else begin
                state_q   <= state_d;
                overrun_q <= drop;

                if (restart) begin
                    per_q  <= CW'(1);
                    high_q <= CW'(1);
                end else if (state_q == MEASURE) begin
                    per_q  <= per_q + CW'(1);
                    high_q <= high_q + {{(CW-1){1'b0}}, lvl};
                end

                if (rise) begin
                    to_cnt_q  <= CW'(1);
                    to_done_q <= 1'b0;
                end else if (fire) begin
                    to_done_q <= 1'b1;
                end else if (!to_done_q) begin
                    to_cnt_q  <= to_cnt_q + CW'(1);
                end

                if (start_div) begin
                    busy_q    <= 1'b1;
                    div_cnt_q <= DCW'(RESOLUTION);
                    rem_q     <= high_q;
                    div_p_q   <= per_q;
                    quo_q     <= '0;
                end else if (busy_q) begin
                    rem_q     <= rem_sub;
                    quo_q     <= quo_next[RESOLUTION-2:0];
                    div_cnt_q <= div_cnt_q - DCW'(1);
                    if (div_last) busy_q <= 1'b0;
                end

                // A divider result takes priority; a coincident timeout is reported next cycle.
                if (div_last) begin
                    duty_q    <= quo_next;
                    period_q  <= div_p_q;
                    valid_q   <= 1'b1;
                    tflag_q   <= 1'b0;
                    to_pend_q <= fire;
                end else if (fire || to_pend_q) begin
                    duty_q    <= {RESOLUTION{lvl}};
                    period_q  <= '0;
                    valid_q   <= 1'b1;
                    tflag_q   <= 1'b1;
                    to_pend_q <= 1'b0;
                end
            end
        end
    end

    assign bus.duty_out     = duty_q;
    assign bus.period_out   = period_q;
    assign bus.valid        = valid_q;
    assign bus.timeout_flag = tflag_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_pwm_demod.sv
// Randomized and directed PWM waveforms; expected reports come from a per-period model and are
// queued when each rising edge is driven, then matched by a monitor on every valid strobe.
module tb_pwm_demod;
    localparam int R  = 8;
    localparam int CW = 16;
    localparam int TO = 600;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pwm_demod_if #(.RESOLUTION(R), .COUNTER_WIDTH(CW)) bus ();

    pwm_demod #(.RESOLUTION(R), .COUNTER_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int duty;
        int period;
        int tflag;
        int cyc;
    } exp_t;

    typedef struct {
        int h;
        int l;
        int m;
    } seg_t;

    exp_t sb[$];
    exp_t me;
    seg_t segs[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int exp_ovr = 0;
    int hold_duty = 0, hold_period = 0, hold_tflag = 0;

    bit armed = 1'b0;
    int last_rise = 0, last_high = 0, div_free = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Period model: a rising edge closes the previous period; timing is counted from the raw edge.
    task automatic on_rise(input int n, input int high, input int low, input bit kill);
        exp_t e;
        if (kill) begin
            armed    = 1'b0;
            div_free = 0;
            return;
        end
        if (armed) begin
            if (n >= div_free) begin
                e.period = n - last_rise;
                e.duty   = (last_high * (1 << R)) / e.period;
                e.tflag  = 1;
                e.tflag  = 0;
                e.cyc    = n + R + 3;
                sb.push_back(e);
                div_free = n + R + 1;
            end else begin
                exp_ovr++;
            end
        end
        armed     = 1'b1;
        last_rise = n;
        last_high = high;
        if (high + low > TO) begin
            e.duty   = (high > TO) ? ((1 << R) - 1) : 0;
            e.period = 0;
            e.tflag  = 1;
            e.cyc    = n + TO + 3;
            sb.push_back(e);
            armed = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_duty"},    int'(bus.duty_out), 0);
        check({tag, "_period"},  int'(bus.period_out), 0);
        check({tag, "_valid"},   int'(bus.valid), 0);
        check({tag, "_tflag"},   int'(bus.timeout_flag), 0);
        check({tag, "_overrun"}, int'(bus.overrun), 0);
    endtask

    // mode 0: plain period, 1: reset pulse at E+4, 2: enable low for 50 cycles mid-period
    task automatic drive_seg(input int high, input int low, input int mode);
        for (int i = 0; i < high + low; i++) begin
            @(posedge clk);
            #1;
            bus.pwm_in = (i < high);
            if (i == 0) on_rise(cyc, high, low, mode == 1);
            if (mode == 1 && i == 6) reset_n = 1'b0;
            if (mode == 1 && i == 7) begin
                reset_n = 1'b1;
                check_zero("midreset");
            end
            if (mode == 2 && i == 40) begin
                bus.enable = 1'b0;
                armed      = 1'b0;
            end
            if (mode == 2 && i == 60) begin
                check("hold_duty",   int'(bus.duty_out), hold_duty);
                check("hold_period", int'(bus.period_out), hold_period);
                check("hold_tflag",  int'(bus.timeout_flag), hold_tflag);
            end
            if (mode == 2 && i == 90) bus.enable = 1'b1;
        end
    endtask

    task automatic add(input int h, input int l, input int m);
        seg_t s;
        s.h = h;
        s.l = l;
        s.m = m;
        segs.push_back(s);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            hold_duty   = 0;
            hold_period = 0;
            hold_tflag  = 0;
        end
        if (bus.overrun) ovr_cnt++;
        if (bus.valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                me = sb.pop_front();
                check("duty",    int'(bus.duty_out), me.duty);
                check("period",  int'(bus.period_out), me.period);
                check("tflag",   int'(bus.timeout_flag), me.tflag);
                check("latency", cyc, me.cyc);
                hold_duty   = me.duty;
                hold_period = me.period;
                hold_tflag  = me.tflag;
            end
        end
    end

    initial begin
        bus.enable = 1'b1;
        bus.pwm_in = 1'b0;
        reset_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;

        repeat (4) add(25, 75, 0);
        add(128, 128, 0);
        add(255, 1, 0);
        add(25, 75, 0);
        add(TO + 10, 20, 0);
        add(30, 70, 0);
        add(10, TO + 10, 0);
        add(25, 75, 0);
        add(25, 75, 0);
        add(25, 75, 0);
        repeat (4) add(3, 3, 0);
        add(25, 75, 0);
        add(25, 75, 2);
        add(25, 75, 0);
        add(25, 75, 0);
        add(5, 95, 0);
        add(5, 95, 1);
        add(5, 95, 0);
        add(5, 95, 0);
        add(25, 75, 0);
        for (int k = 0; k < 14; k++) add(int'($urandom_range(1, 60)), int'($urandom_range(1, 120)), 0);
        add(25, TO + 50, 0);

        foreach (segs[k]) drive_seg(segs[k].h, segs[k].l, segs[k].m);

        for (int k = 0; k < 2000 && sb.size() != 0; k++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("pending_reports", sb.size(), 0);
        check("overrun_count", ovr_cnt, exp_ovr);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
